// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end for a memory_sync style memory. Turns byte-addressed
//   byte/half/word requests into word-aligned accesses: builds byte enables,
//   steers store data onto the right lanes, and extracts + extends load data.
//   Misaligned requests and the illegal size code are answered with an error
//   response and never reach the memory.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   req_*              request side (valid/ready handshake, see below)
//   resp_valid         one-cycle completion pulse
//   resp_rdata         load result (0 for stores and errors)
//   resp_error         misaligned address or illegal size, qualified by resp_valid
//   mem_*              memory_sync initiator port
//   dbg_state          current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Handshake: a request is taken on a rising clk edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE; anything offered while
// it is 0 is ignored (not queued). Every accepted request yields exactly one
// resp_valid pulse unless reset intervenes.

module mem_access_unit #(
  parameter int LATENCY    = 1,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data_out,
  input  logic [31:0]           mem_data_in,
  output logic [3:0]            mem_byte_enable,
  output logic                  mem_master_enable,
  output logic                  mem_read_write,
  output logic [1:0]            dbg_state
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_error_q;

  logic                  req_illegal;
  logic [3:0]            req_be;
  logic [31:0]           req_placed;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           rd_aligned;

  // Request decode: alignment check, byte enables and lane placement.
  always_comb begin
    req_illegal = 1'b0;
    req_be      = 4'b0000;
    req_placed  = 32'h0;
    case (req_size)
      SZ_BYTE: begin
        req_be     = 4'b0001 << req_addr[1:0];
        req_placed = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        req_illegal = req_addr[0];
        req_be      = req_addr[1] ? 4'b1100 : 4'b0011;
        req_placed  = {2{req_wdata[15:0]}};
      end
      SZ_WORD: begin
        req_illegal = |req_addr[1:0];
        req_be      = 4'b1111;
        req_placed  = req_wdata;
      end
      default: req_illegal = 1'b1;
    endcase
  end

  // Read extraction from the latched lane and size.
  always_comb begin
    rd_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: rd_byte = mem_data_in[7:0];
      2'd1: rd_byte = mem_data_in[15:8];
      2'd2: rd_byte = mem_data_in[23:16];
      2'd3: rd_byte = mem_data_in[31:24];
      default: rd_byte = 8'h00;
    endcase
    rd_half = addr_q[1] ? mem_data_in[31:16] : mem_data_in[15:0];
    case (size_q)
      SZ_BYTE: rd_aligned = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: rd_aligned = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: rd_aligned = mem_data_in;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_illegal ? RESP : ACCESS;
        end
      end
      // cnt_q == 1 marks the edge on which the counter reaches 0.
      ACCESS: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          resp_rdata_q <= 32'h0;
          resp_error_q <= 1'b0;
          if (req_valid) begin
            if (req_illegal) begin
              resp_error_q <= 1'b1;
            end else begin
              addr_q  <= req_addr;
              write_q <= req_write;
              size_q  <= req_size;
              uns_q   <= req_unsigned;
              be_q    <= req_be;
              wdata_q <= req_placed;
              cnt_q   <= LAT;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1 && !write_q) begin
            resp_rdata_q <= rd_aligned;
          end
        end
        RESP: begin
          resp_rdata_q <= 32'h0;
          resp_error_q <= 1'b0;
        end
        default: begin
          resp_rdata_q <= 32'h0;
          resp_error_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory port is driven only during ACCESS; elsewhere it sits at its
  // idle values (read, disabled, zero address/data/enables).
  always_comb begin
    mem_addr          = '0;
    mem_data_out      = 32'h0;
    mem_byte_enable   = 4'b0000;
    mem_master_enable = 1'b0;
    mem_read_write    = 1'b1;
    if (state_q == ACCESS) begin
      mem_addr          = {addr_q[ADDR_WIDTH-1:2], 2'b00};
      mem_data_out      = wdata_q;
      mem_byte_enable   = be_q;
      mem_master_enable = 1'b1;
      mem_read_write    = ~write_q;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int LAT = 3;
  localparam int NV  = 22;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_byte_enable;
  logic        mem_master_enable;
  logic        mem_read_write;
  logic [1:0]  dbg_state;

  mem_access_unit #(.LATENCY(LAT), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .mem_byte_enable(mem_byte_enable),
    .mem_master_enable(mem_master_enable), .mem_read_write(mem_read_write),
    .dbg_state(dbg_state)
  );

  // ---------------- memory_sync model ----------------
  function automatic logic [31:0] init_word(input int i);
    return 32'h44332211 + 32'(i) * 32'h01010101;
  endfunction

  logic [31:0] mem [0:15];
  logic        mem_init = 1'b1;
  int          acc_cnt = 0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_master_enable && !mem_read_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_enable[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_data_out[8*b +: 8];
    end
    acc_cnt <= mem_master_enable ? acc_cnt + 1 : 0;
  end

  // Read data is only valid once the access has been held for LAT cycles.
  assign mem_data_in = (mem_master_enable && mem_read_write && acc_cnt >= LAT - 1)
                       ? mem[mem_addr[5:2]] : 32'hA5A5A5A5;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response scoreboard: pops one expected {error, rdata} per resp_valid.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_error", 64'(resp_error), 64'(e[32]));
        check("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs [0:NV-1];

  function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input logic [3:0] be, input logic [31:0] dout);
    vec_t v;
    v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.be = be; v.dout = dout;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input vec_t v);
    int n;
    int bad;
    int exp_n;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back({v.err, v.rdata});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr = $urandom_range(0, 255);
    n = 1;
    bad = 0;
    while (!resp_valid && n <= 20) begin
      if (v.err || !mem_master_enable || mem_addr !== {v.addr[31:2], 2'b00} ||
          mem_byte_enable !== v.be || mem_read_write !== !v.wr ||
          (v.wr && mem_data_out !== v.dout) || req_ready !== 1'b0)
        bad++;
      @(negedge clk);
      n++;
    end
    exp_n = v.err ? 1 : LAT + 1;
    check("resp_latency", 64'(n), 64'(exp_n));
    check("mem_access_signals", 64'(bad), 64'd0);
    check("resp_mem_disabled", 64'({mem_master_enable, req_ready}), 64'd0);
    @(negedge clk);
    check("resp_cleared", {31'h0, resp_valid, resp_error, resp_rdata}, 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp", {31'h0, resp_valid, resp_error, resp_rdata}, 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_dout", 64'(mem_data_out), 64'd0);
    check("rst_mem_ctl", 64'({mem_byte_enable, mem_master_enable, mem_read_write}), 64'b0000_0_1);
    check("rst_state", 64'(dbg_state), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    int seen;
    int prev_acc;
    int n_acc;
    int bad;
    logic [31:0] acc_addr;

    vecs[0]  = mk(1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0,        4'b1111, 32'hDEADBEEF);
    vecs[1]  = mk(0, 2'b10, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF, 4'b1111, 32'h0);
    vecs[2]  = mk(1, 2'b00, 0, 32'h05, 32'h12345680, 0, 32'h0,        4'b0010, 32'h80808080);
    vecs[3]  = mk(0, 2'b00, 0, 32'h05, 32'h0,        0, 32'hFFFFFF80, 4'b0010, 32'h0);
    vecs[4]  = mk(0, 2'b00, 1, 32'h05, 32'h0,        0, 32'h00000080, 4'b0010, 32'h0);
    vecs[5]  = mk(1, 2'b01, 1, 32'h06, 32'hABCD8001, 0, 32'h0,        4'b1100, 32'h80018001);
    vecs[6]  = mk(0, 2'b01, 0, 32'h06, 32'h0,        0, 32'hFFFF8001, 4'b1100, 32'h0);
    vecs[7]  = mk(0, 2'b01, 1, 32'h04, 32'h0,        0, 32'h00008012, 4'b0011, 32'h0);
    vecs[8]  = mk(0, 2'b00, 1, 32'h04, 32'h0,        0, 32'h00000012, 4'b0001, 32'h0);
    vecs[9]  = mk(0, 2'b10, 0, 32'h04, 32'h0,        0, 32'h80018012, 4'b1111, 32'h0);
    vecs[10] = mk(0, 2'b00, 0, 32'h0B, 32'h0,        0, 32'hFFFFFFDE, 4'b1000, 32'h0);
    vecs[11] = mk(0, 2'b00, 1, 32'h0A, 32'h0,        0, 32'h000000AD, 4'b0100, 32'h0);
    vecs[12] = mk(0, 2'b01, 0, 32'h08, 32'h0,        0, 32'hFFFFBEEF, 4'b0011, 32'h0);
    vecs[13] = mk(0, 2'b01, 1, 32'h0A, 32'h0,        0, 32'h0000DEAD, 4'b1100, 32'h0);
    vecs[14] = mk(0, 2'b10, 0, 32'h0C, 32'h0,        0, 32'h47362514, 4'b1111, 32'h0);
    vecs[15] = mk(0, 2'b10, 0, 32'h02, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[16] = mk(1, 2'b01, 0, 32'h03, 32'h1234,     1, 32'h0,        4'b0000, 32'h0);
    vecs[17] = mk(0, 2'b11, 0, 32'h00, 32'h0,        1, 32'h0,        4'b0000, 32'h0);
    vecs[18] = mk(0, 2'b00, 0, 32'h07, 32'h0,        0, 32'hFFFFFF80, 4'b1000, 32'h0);
    vecs[19] = mk(1, 2'b00, 0, 32'h0F, 32'h0000007F, 0, 32'h0,        4'b1000, 32'h7F7F7F7F);
    vecs[20] = mk(0, 2'b00, 0, 32'h0F, 32'h0,        0, 32'h0000007F, 4'b1000, 32'h0);
    vecs[21] = mk(0, 2'b10, 1, 32'h0C, 32'h0,        0, 32'h7F362514, 4'b1111, 32'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    mem_init = 1'b0;

    // Table-driven requests.
    for (int i = 0; i < NV; i++) do_req(vecs[i]);

    // Reset one cycle into an access: everything back to idle at once,
    // and the abandoned load never responds.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_access_enable", 64'(mem_master_enable), 64'd1);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("no_resp_after_reset", 64'(seen), 64'd0);
    do_req(vecs[1]);

    // Continuous req_valid with a changing address every cycle.
    prev_acc = -1;
    n_acc = 0;
    bad = 0;
    acc_addr = 32'h0;
    for (int cyc = 0; cyc < 4 * (LAT + 2); cyc++) begin
      @(negedge clk);
      if (mem_master_enable && mem_addr !== acc_addr) bad++;
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10;
      req_addr = 32'(16 + 4 * (cyc % 4));
      if (req_ready) begin
        if (prev_acc >= 0) check("accept_spacing", 64'(cyc - prev_acc), 64'(LAT + 2));
        prev_acc = cyc;
        n_acc++;
        acc_addr = req_addr;
        exp_q.push_back({1'b0, init_word(4 + cyc % 4)});
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("hs_accepts", 64'(n_acc), 64'd4);
    check("hs_mem_stable", 64'(bad), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
